// File: rtl/cla_nibble_serial_adder.sv
// rtl/cla_nibble_serial_adder.sv - multi-cycle wide adder built from a 4-bit carry-lookahead slice
module cla_nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             ovf
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry;
   logic [IW-1:0]    idx;
   logic [WIDTH:0]   sum_q;
   logic             ovf_q;

   logic [3:0]       an, bn, g, p;
   logic             c1, c2, c3, c4;
   logic             last;

   assign an   = a_q[{idx, 2'b00} +: 4];
   assign bn   = b_q[{idx, 2'b00} +: 4];
   assign g    = an & bn;
   assign p    = an ^ bn;
   assign last = (idx == IW'(NIB - 1));

   // Every carry is a flat sum of products off the registered carry, so no ripple inside the slice.
   assign c1 = g[0] | (p[0] & carry);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
   assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_q;
   assign ovf       = ovf_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid)  state_n = RUN;
         RUN:     if (last)      state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  carry <= cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               // Unwritten nibbles deliberately keep the previous result until overwritten.
               sum_q[{idx, 2'b00} +: 4] <= p ^ {c3, c2, c1, carry};
               carry <= c4;
               idx   <= idx + 1'b1;
               if (last) begin
                  sum_q[WIDTH] <= c4;
                  ovf_q        <= c3 ^ c4;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb/tb_cla_nibble_serial_adder.sv - scoreboard bench for cla_nibble_serial_adder
module tb_cla_nibble_serial_adder;
   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W:0]    sum;
   logic          ovf;

   int            total = 0;
   int            bad = 0;
   bit            rand_bp = 1'b0;
   logic [W+1:0]  exp_q[$];

   cla_nibble_serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference: exact integer sum, and overflow from the true signed result leaving the W-bit range.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      longint unsigned us;
      longint          sx, sy, ss;
      logic [W:0]      s;
      logic            o;
      us = longint'(x) + longint'(y) + longint'(c);
      s  = us[W:0];
      sx = longint'(x) - (x[W-1] ? (longint'(1) << W) : 0);
      sy = longint'(y) - (y[W-1] ? (longint'(1) << W) : 0);
      ss = sx + sy + longint'(c);
      o  = (ss > ((longint'(1) << (W-1)) - 1)) || (ss < -(longint'(1) << (W-1)));
      return {o, s};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      logic [W+1:0] e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(e[W:0]));
            check("ovf", 32'(ovf), 32'(e[W+1]));
         end
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (rand_bp) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      if (acc) exp_q.push_back(model(ta, tb_v, tc));
      else     check("accept_timeout", 32'(acc), 32'(1));
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk); #1;
         if (rand_bp) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'(0));
      out_ready = 1'b1;
   endtask

   initial begin
      int           n;
      logic [W+1:0] e;
      logic [W-1:0] ra, rb;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_sum", 32'(sum), 32'(0));
      check("rst_ovf", 32'(ovf), 32'(0));

      // Latency and handshake timing on the carry-through-all-nibbles case.
      @(posedge clk); #1;
      send(16'hFFFF, 16'h0001, 1'b0);
      @(negedge clk);
      check("in_ready_busy", 32'(in_ready), 32'(0));
      n = 1;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'(NIB + 1));
      @(negedge clk);
      check("idle_after_done", 32'(in_ready), 32'(1));
      check("valid_after_done", 32'(out_valid), 32'(0));

      @(posedge clk); #1;
      send(16'h7FFF, 16'h0001, 1'b0);
      send(16'h8000, 16'h8000, 1'b0);
      send(16'h0000, 16'h0000, 1'b1);
      send(16'h1234, 16'h4321, 1'b1);
      wait_done();

      // Backpressure: result must hold steady while the consumer stalls.
      out_ready = 1'b0;
      e = model(16'h8001, 16'h8001, 1'b1);
      send(16'h8001, 16'h8001, 1'b1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", 32'(out_valid), 32'(1));
         check("bp_sum", 32'(sum), 32'(e[W:0]));
         check("bp_ovf", 32'(ovf), 32'(e[W+1]));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_in_ready", 32'(in_ready), 32'(1));
      check("bp_release_valid", 32'(out_valid), 32'(0));

      // Operands offered mid-operation must be ignored.
      @(posedge clk); #1;
      send(16'h0F0F, 16'h00F1, 1'b0);
      @(posedge clk); #1;
      a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done();
      repeat (3) @(posedge clk);
      #1;

      // Reset during RUN nibble 2 discards the operation.
      send(16'hABCD, 16'h1357, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      e = exp_q.pop_back();
      @(negedge clk);
      check("midrst_in_ready", 32'(in_ready), 32'(1));
      check("midrst_valid", 32'(out_valid), 32'(0));
      check("midrst_sum", 32'(sum), 32'(0));
      check("midrst_ovf", 32'(ovf), 32'(0));
      @(posedge clk); #1;
      send(16'h0002, 16'h0003, 1'b0);
      wait_done();

      rand_bp = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 8 == 0) rb = ~ra;
         send(ra, rb, 1'($urandom_range(0, 1)));
      end
      wait_done();
      rand_bp = 1'b0;
      repeat (5) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
